riscv_compressed_encoder: RTL and testbench
===========================================

RISCV_COMPRESSED_ENCODER -- requirements
Module: riscv_compressed_encoder

Interface
REQ-001 SHALL have parameter PAD_HALFWORD, default 16'h0001 (c.nop), the halfword used to pad a flushed residue.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port in_valid_i, input, 1 bit: RV32 instruction offered.
REQ-005 SHALL have port in_instr_i, input, 32 bits: uncompressed RV32 instruction.
REQ-006 SHALL have port in_ready_o, output, 1 bit: instruction accepted when in_valid_i and in_ready_o are both high.
REQ-007 SHALL have port flush_i, input, 1 bit: level request to drain the residue halfword.
REQ-008 SHALL have port flush_done_o, output, 1 bit: flush complete.
REQ-009 SHALL have port out_valid_o, output, 1 bit: packed word valid.
REQ-010 SHALL have port out_data_o, output, 32 bits: packed fetch word; the lower halfword is first in program order.
REQ-011 SHALL have port out_ready_i, input, 1 bit: consumer accepts the word.
REQ-012 SHALL have port err_o, output, 1 bit: one-cycle pulse when an accepted input has in_instr_i[1:0] != 2'b11.

Function
REQ-013 SHALL map each accepted instruction to its RVC form when an exact RVC equivalent exists; otherwise the instruction passes through unchanged as 32 bits.
REQ-014 SHALL compress the following set (RVC field constraints hold in each case):
- c.addi, c.li, c.lui, c.addi16sp, c.addi4spn
- c.lw, c.sw, c.lwsp, c.swsp
- c.slli, c.srli, c.srai, c.andi
- c.sub, c.xor, c.or, c.and
- c.mv, c.add, c.jr, c.jalr, c.ebreak
REQ-015 SHALL NOT emit reserved or hint encodings: no rd = x0 (except c.nop from addi x0,x0,0), no zero immediate where RVC forbids it, no shamt[5] = 1.
REQ-016 SHALL implement a two-state packer:
- EMPTY, compressed c -> residue = c, go to HALF, no output.
- EMPTY, uncompressed w -> output w, stay EMPTY.
- HALF (residue r), compressed c -> output {c, r}, go to EMPTY.
- HALF (residue r), uncompressed w -> output {w[15:0], r}, residue = w[31:16], stay HALF.
REQ-017 SHALL register out_data_o and out_valid_o; input-to-output latency is one cycle for transitions that produce a word.
REQ-018 SHALL drive in_ready_o = (!out_valid_o || out_ready_i) && !flush_i.
REQ-019 SHALL hold out_data_o stable while out_valid_o && !out_ready_i.
REQ-020 SHALL, when flush_i is high in HALF and the output slot is free, output {PAD_HALFWORD, r} and go to EMPTY.
REQ-021 SHALL drive flush_done_o = flush_i && state == EMPTY && !out_valid_o; a flush in EMPTY costs no output word.
REQ-022 SHALL, on an err_o input, pass the 32 bits through as uncompressed (path of REQ-016).

Reset
REQ-023 SHALL, while rst_n is low at a clock edge, go to EMPTY, discard the residue, and drive out_valid_o = 0, out_data_o = 0, err_o = 0; reset mid-HALF loses the residue by design.

Configuration
REQ-024 SHALL, with macro RISCV_CMPR_CTRL_FLOW_EN defined, also compress jal x0/x1 (c.j/c.jal) and beq/bne rs1', x0 (c.beqz/c.bnez) when the offset fits; without it, all jal and branch instructions pass through uncompressed.

Structure
REQ-025 SHALL take RVC opcode/funct3 constants and the packer state enum from riscv_defines, shared with the compressed decoder.
REQ-026 SHALL place the combinational compression function in sub-module riscv_compress_lookup (32-bit in; 16-bit out plus can_compress flag).

Verification
REQ-027 SHALL cover: 32'h00140413 (addi x8,x8,1) twice from EMPTY -> one word 32'h04050405.
REQ-028 SHALL cover: 32'h123452B7 (lui) in EMPTY -> out_data_o = 32'h123452B7 next cycle, state EMPTY.
REQ-029 SHALL cover: 32'h00140413 then 32'h123452B7 -> 32'h52B70405, residue 16'h1234; then flush_i -> 32'h00011234, flush_done_o high once the output has drained.
REQ-030 SHALL cover: out_ready_i low for 3 cycles with a word pending -> out_data_o stable, in_ready_o = 0 throughout.
REQ-031 SHALL cover: rst_n low in HALF -> next cycle out_valid_o = 0, state EMPTY, the following addi is held (no output).
REQ-032 SHALL cover: 32'h0080006F (jal x0,8) -> with RISCV_CMPR_CTRL_FLOW_EN the residue is 16'hA021; without it the word 32'h0080006F is output.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared RVC encoding constants and packer state, used by the compressed encoder and decoder.
package riscv_defines;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } packer_state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INSTR_EBREAK = 32'h00100073;

    localparam logic [1:0] RVC_Q0 = 2'b00;
    localparam logic [1:0] RVC_Q1 = 2'b01;
    localparam logic [1:0] RVC_Q2 = 2'b10;

    localparam logic [2:0] C0_ADDI4SPN  = 3'b000;
    localparam logic [2:0] C0_LW        = 3'b010;
    localparam logic [2:0] C0_SW        = 3'b110;
    localparam logic [2:0] C1_ADDI      = 3'b000;
    localparam logic [2:0] C1_JAL       = 3'b001;
    localparam logic [2:0] C1_LI        = 3'b010;
    localparam logic [2:0] C1_LUI       = 3'b011;
    localparam logic [2:0] C1_MISC_ALU  = 3'b100;
    localparam logic [2:0] C1_J         = 3'b101;
    localparam logic [2:0] C1_BEQZ      = 3'b110;
    localparam logic [2:0] C1_BNEZ      = 3'b111;
    localparam logic [2:0] C2_SLLI      = 3'b000;
    localparam logic [2:0] C2_LWSP      = 3'b010;
    localparam logic [2:0] C2_JR_MV_ADD = 3'b100;
    localparam logic [2:0] C2_SWSP      = 3'b110;

    localparam logic [15:0] RVC_NOP    = 16'h0001;
    localparam logic [15:0] RVC_EBREAK = 16'h9002;

endpackage

// File: rtl/riscv_compress_lookup.sv
// Combinational RV32 -> RVC mapping; reserved/hint encodings are never produced.
// Macro RISCV_CMPR_CTRL_FLOW_EN adds c.j/c.jal/c.beqz/c.bnez.
module riscv_compress_lookup
    import riscv_defines::*;
(
    input  logic [31:0] instr,
    output logic [15:0] instr_c,
    output logic        can_compress
);

    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm_i;
    logic [11:0] imm_s;
    logic        rd_p;
    logic        rs1_p;
    logic        rs2_p;
    logic        imm_i_fits6;
    logic        imm_i_nz;
    logic        alu_ok;
    logic [1:0]  alu_sel;

    assign rd          = instr[11:7];
    assign rs1         = instr[19:15];
    assign rs2         = instr[24:20];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    assign imm_i       = instr[31:20];
    assign imm_s       = {instr[31:25], instr[11:7]};
    assign rd_p        = (rd[4:3] == 2'b01);
    assign rs1_p       = (rs1[4:3] == 2'b01);
    assign rs2_p       = (rs2[4:3] == 2'b01);
    assign imm_i_fits6 = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7F);
    assign imm_i_nz    = (imm_i != 12'h000);

`ifdef RISCV_CMPR_CTRL_FLOW_EN
    logic [20:1] imm_j;
    logic [12:1] imm_b;
    assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21]};
    assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8]};
`endif

    // Register-register ALU ops that have a CA-format equivalent
    always_comb begin
        alu_ok  = 1'b0;
        alu_sel = 2'b00;
        if (rd_p && rs1 == rd && rs2_p) begin
            if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                alu_ok = 1'b1; alu_sel = 2'b00;
            end else if (funct7 == 7'b0000000 && funct3 == 3'b100) begin
                alu_ok = 1'b1; alu_sel = 2'b01;
            end else if (funct7 == 7'b0000000 && funct3 == 3'b110) begin
                alu_ok = 1'b1; alu_sel = 2'b10;
            end else if (funct7 == 7'b0000000 && funct3 == 3'b111) begin
                alu_ok = 1'b1; alu_sel = 2'b11;
            end
        end
    end

    always_comb begin
        instr_c      = 16'h0000;
        can_compress = 1'b0;
        case (instr[6:0])
            OPC_OP_IMM: begin
                case (funct3)
                    3'b000: begin
                        if (rd == 5'd0 && rs1 == 5'd0 && !imm_i_nz) begin
                            instr_c = RVC_NOP; can_compress = 1'b1;
                        end else if (rd != 5'd0 && rs1 == rd && imm_i_fits6 && imm_i_nz) begin
                            instr_c = {C1_ADDI, imm_i[5], rd, imm_i[4:0], RVC_Q1}; can_compress = 1'b1;
                        end else if (rd != 5'd0 && rs1 == 5'd0 && imm_i_fits6) begin
                            instr_c = {C1_LI, imm_i[5], rd, imm_i[4:0], RVC_Q1}; can_compress = 1'b1;
                        end else if (rd == 5'd2 && rs1 == 5'd2 && imm_i_nz && imm_i[3:0] == 4'h0 &&
                                     (imm_i[11:9] == 3'b000 || imm_i[11:9] == 3'b111)) begin
                            instr_c = {C1_LUI, imm_i[9], 5'd2, imm_i[4], imm_i[6], imm_i[8:7], imm_i[5], RVC_Q1};
                            can_compress = 1'b1;
                        end else if (rd_p && rs1 == 5'd2 && imm_i_nz && imm_i[11:10] == 2'b00 &&
                                     imm_i[1:0] == 2'b00) begin
                            instr_c = {C0_ADDI4SPN, imm_i[5:4], imm_i[9:6], imm_i[2], imm_i[3], rd[2:0], RVC_Q0};
                            can_compress = 1'b1;
                        end
                    end
                    3'b001: begin
                        if (funct7 == 7'b0000000 && rd != 5'd0 && rs1 == rd && rs2 != 5'd0) begin
                            instr_c = {C2_SLLI, 1'b0, rd, rs2, RVC_Q2}; can_compress = 1'b1;
                        end
                    end
                    3'b101: begin
                        if ((funct7 == 7'b0000000 || funct7 == 7'b0100000) && rd_p && rs1 == rd && rs2 != 5'd0) begin
                            instr_c = {C1_MISC_ALU, 1'b0, 1'b0, funct7[5], rd[2:0], rs2, RVC_Q1};
                            can_compress = 1'b1;
                        end
                    end
                    3'b111: begin
                        if (rd_p && rs1 == rd && imm_i_fits6) begin
                            instr_c = {C1_MISC_ALU, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], RVC_Q1};
                            can_compress = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            OPC_LUI: begin
                // Upper immediate must sign-extend from bit 17 and be nonzero
                if (rd != 5'd0 && rd != 5'd2 && instr[17:12] != 6'd0 &&
                    (instr[31:17] == 15'h0000 || instr[31:17] == 15'h7FFF)) begin
                    instr_c = {C1_LUI, instr[17], rd, instr[16:12], RVC_Q1}; can_compress = 1'b1;
                end
            end
            OPC_OP: begin
                if (funct7 == 7'b0000000 && funct3 == 3'b000 && rd != 5'd0 && rs2 != 5'd0 && rs1 == 5'd0) begin
                    instr_c = {C2_JR_MV_ADD, 1'b0, rd, rs2, RVC_Q2}; can_compress = 1'b1;
                end else if (funct7 == 7'b0000000 && funct3 == 3'b000 && rd != 5'd0 && rs2 != 5'd0 && rs1 == rd) begin
                    instr_c = {C2_JR_MV_ADD, 1'b1, rd, rs2, RVC_Q2}; can_compress = 1'b1;
                end else if (alu_ok) begin
                    instr_c = {C1_MISC_ALU, 1'b0, 2'b11, rd[2:0], alu_sel, rs2[2:0], RVC_Q1};
                    can_compress = 1'b1;
                end
            end
            OPC_LOAD: begin
                if (funct3 == 3'b010) begin
                    if (rd_p && rs1_p && imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'b00) begin
                        instr_c = {C0_LW, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], RVC_Q0};
                        can_compress = 1'b1;
                    end else if (rd != 5'd0 && rs1 == 5'd2 && imm_i[11:8] == 4'h0 && imm_i[1:0] == 2'b00) begin
                        instr_c = {C2_LWSP, imm_i[5], rd, imm_i[4:2], imm_i[7:6], RVC_Q2};
                        can_compress = 1'b1;
                    end
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b010) begin
                    if (rs1_p && rs2_p && imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'b00) begin
                        instr_c = {C0_SW, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], RVC_Q0};
                        can_compress = 1'b1;
                    end else if (rs1 == 5'd2 && imm_s[11:8] == 4'h0 && imm_s[1:0] == 2'b00) begin
                        instr_c = {C2_SWSP, imm_s[5:2], imm_s[7:6], rs2, RVC_Q2};
                        can_compress = 1'b1;
                    end
                end
            end
            OPC_JALR: begin
                if (funct3 == 3'b000 && !imm_i_nz && rs1 != 5'd0 && (rd == 5'd0 || rd == 5'd1)) begin
                    instr_c = {C2_JR_MV_ADD, rd[0], rs1, 5'd0, RVC_Q2}; can_compress = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                if (instr == INSTR_EBREAK) begin
                    instr_c = RVC_EBREAK; can_compress = 1'b1;
                end
            end
`ifdef RISCV_CMPR_CTRL_FLOW_EN
            OPC_JAL: begin
                if ((rd == 5'd0 || rd == 5'd1) &&
                    (imm_j[20:11] == 10'h000 || imm_j[20:11] == 10'h3FF)) begin
                    instr_c = {(rd[0] ? C1_JAL : C1_J), imm_j[11], imm_j[4], imm_j[9:8], imm_j[10],
                               imm_j[6], imm_j[7], imm_j[3:1], imm_j[5], RVC_Q1};
                    can_compress = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if ((funct3 == 3'b000 || funct3 == 3'b001) && rs2 == 5'd0 && rs1_p &&
                    (imm_b[12:8] == 5'h00 || imm_b[12:8] == 5'h1F)) begin
                    instr_c = {(funct3[0] ? C1_BNEZ : C1_BEQZ), imm_b[8], imm_b[4:3], rs1[2:0],
                               imm_b[7:6], imm_b[2:1], imm_b[5], RVC_Q1};
                    can_compress = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_compressed_encoder.sv
// Compresses RV32 instructions to RVC where exact and packs halfwords into 32-bit fetch words.
// Control-flow compression is enabled by defining RISCV_CMPR_CTRL_FLOW_EN.
module riscv_compressed_encoder
    import riscv_defines::*;
#(
    parameter logic [15:0] PAD_HALFWORD = 16'h0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    input  logic [31:0] in_instr_i,
    output logic        in_ready_o,
    input  logic        flush_i,
    output logic        flush_done_o,
    output logic        out_valid_o,
    output logic [31:0] out_data_o,
    input  logic        out_ready_i,
    output logic        err_o
);

    packer_state_t state;
    packer_state_t state_next;
    logic [15:0]   residue;
    logic [15:0]   residue_next;
    logic [31:0]   data_next;
    logic          valid_next;
    logic [15:0]   instr_c;
    logic          can_compress;
    logic          slot_free;
    logic          accept;

    riscv_compress_lookup u_lookup (
        .instr        (in_instr_i),
        .instr_c      (instr_c),
        .can_compress (can_compress)
    );

    assign slot_free    = !out_valid_o || out_ready_i;
    assign in_ready_o   = slot_free && !flush_i;
    assign accept       = in_valid_i && in_ready_o;
    assign flush_done_o = flush_i && (state == ST_EMPTY) && !out_valid_o;

    always_comb begin
        state_next   = state;
        residue_next = residue;
        data_next    = out_data_o;
        valid_next   = out_valid_o && !out_ready_i;
        if (accept) begin
            unique case (state)
                ST_EMPTY: begin
                    if (can_compress) begin
                        residue_next = instr_c;
                        state_next   = ST_HALF;
                    end else begin
                        data_next  = in_instr_i;
                        valid_next = 1'b1;
                    end
                end
                ST_HALF: begin
                    valid_next = 1'b1;
                    if (can_compress) begin
                        data_next  = {instr_c, residue};
                        state_next = ST_EMPTY;
                    end else begin
                        // Word straddles two fetch words; its upper half becomes the new residue
                        data_next    = {in_instr_i[15:0], residue};
                        residue_next = in_instr_i[31:16];
                    end
                end
                default: ;
            endcase
        end else if (flush_i && state == ST_HALF && slot_free) begin
            data_next  = {PAD_HALFWORD, residue};
            valid_next = 1'b1;
            state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            out_valid_o <= 1'b0;
            out_data_o  <= 32'h0000_0000;
            err_o       <= 1'b0;
        end else begin
            state       <= state_next;
            out_valid_o <= valid_next;
            out_data_o  <= data_next;
            err_o       <= accept && (in_instr_i[1:0] != 2'b11);
        end
    end

    // Residue is meaningless outside HALF, so it carries no reset
    always_ff @(posedge clk) begin
        residue <= residue_next;
    end

endmodule

// File: tb/tb_riscv_compressed_encoder.sv
// Directed bench for riscv_compressed_encoder: packer transitions, backpressure, flush, reset, RVC mapping.
module tb_riscv_compressed_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid_i;
    logic [31:0] in_instr_i;
    logic        in_ready_o;
    logic        flush_i;
    logic        flush_done_o;
    logic        out_valid_o;
    logic [31:0] out_data_o;
    logic        out_ready_i;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    riscv_compressed_encoder #(.PAD_HALFWORD(16'h0001)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid_i),
        .in_instr_i   (in_instr_i),
        .in_ready_o   (in_ready_o),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_ready_i  (out_ready_i),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int NV = 20;
    logic [31:0] vec_in [NV] = '{
        32'h00000013, 32'h01F40413, 32'h02040413, 32'h00040413, 32'h00500013,
        32'hFE000293, 32'h02000293, 32'hFC010113, 32'h01010413, 32'h00001537,
        32'h00452483, 32'h00112423, 32'h00B00533, 32'h00008067, 32'h40345413,
        32'h40940433, 32'h00100073, 32'h00029293, 32'hFFF4F493, 32'h00C12083
    };
    logic [31:0] vec_exp [NV] = '{
        32'h00010001, 32'h0001047D, 32'h02040413, 32'h00040413, 32'h00500013,
        32'h00015281, 32'h02000293, 32'h00017139, 32'h00010800, 32'h00016505,
        32'h00014144, 32'h0001C406, 32'h0001852E, 32'h00018082, 32'h0001840D,
        32'h00018C05, 32'h00019002, 32'h00029293, 32'h000198FD, 32'h000140B2
    };

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr);
        in_valid_i = 1'b1;
        in_instr_i = instr;
        step();
        in_valid_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid_i = 1'b0; in_instr_i = 32'h0;
        flush_i = 1'b0; out_ready_i = 1'b1;
        step(); step();
        check("rst_valid", out_valid_o, 0);
        check("rst_data", out_data_o, 0);
        check("rst_err", err_o, 0);
        check("rst_in_ready", in_ready_o, 1);
        check("rst_flush_done", flush_done_o, 0);
        rst_n = 1'b1;

        // Two c.addi halves pair into one word
        send(32'h00140413);
        check("addi1_no_word", out_valid_o, 0);
        send(32'h00140413);
        check("addi2_valid", out_valid_o, 1);
        check("addi2_data", out_data_o, 32'h04050405);
        step();
        check("addi2_drain", out_valid_o, 0);

        // Uncompressible lui from EMPTY passes straight through
        send(32'h123452B7);
        check("lui_valid", out_valid_o, 1);
        check("lui_data", out_data_o, 32'h123452B7);
        step();
        flush_i = 1'b1; #1;
        check("lui_state_empty_flush_done", flush_done_o, 1);
        step();
        check("flush_empty_no_word", out_valid_o, 0);
        flush_i = 1'b0;

        // Straddling lui and padded flush
        send(32'h00140413);
        send(32'h123452B7);
        check("straddle_data", out_data_o, 32'h52B70405);
        flush_i = 1'b1; #1;
        check("flush_half_not_done", flush_done_o, 0);
        check("flush_in_ready", in_ready_o, 0);
        step();
        check("flush_word_valid", out_valid_o, 1);
        check("flush_word_data", out_data_o, 32'h00011234);
        check("flush_pending_not_done", flush_done_o, 0);
        step();
        check("flush_done", flush_done_o, 1);
        flush_i = 1'b0;

        // Backpressure holds the word and blocks input
        out_ready_i = 1'b0;
        send(32'h123452B7);
        in_valid_i = 1'b1; in_instr_i = 32'hABCDE2B7;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_data_%0d", i), out_data_o, 32'h123452B7);
            check($sformatf("stall_ready_%0d", i), in_ready_o, 0);
            step();
        end
        check("stall_valid", out_valid_o, 1);
        check("stall_data_end", out_data_o, 32'h123452B7);
        out_ready_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        check("release_valid", out_valid_o, 1);
        check("release_data", out_data_o, 32'hABCDE2B7);
        step();
        check("release_drain", out_valid_o, 0);

        // Non-32-bit input flags an error and passes through
        send(32'h00000001);
        check("err_pulse", err_o, 1);
        check("err_data", out_data_o, 32'h00000001);
        step();
        check("err_clear", err_o, 0);

        // Reset in HALF drops the residue
        send(32'h00140413);
        rst_n = 1'b0;
        step();
        check("rst_half_valid", out_valid_o, 0);
        check("rst_half_data", out_data_o, 0);
        rst_n = 1'b1;
        send(32'h00140413);
        check("rst_addi_held", out_valid_o, 0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("rst_state_empty", out_data_o, 32'h00010405);
        step();

        // RVC mapping table: compressed ones are flushed out padded
        for (int v = 0; v < NV; v++) begin
            send(vec_in[v]);
            if (!out_valid_o) begin
                flush_i = 1'b1;
                step();
                flush_i = 1'b0;
            end
            check($sformatf("vec%0d_valid", v), out_valid_o, 1);
            check($sformatf("vec%0d_data", v), out_data_o, vec_exp[v]);
            step();
        end

        // jal x0,8
        send(32'h0080006F);
`ifdef RISCV_CMPR_CTRL_FLOW_EN
        check("jal_held", out_valid_o, 0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("jal_cj_data", out_data_o, 32'h0001A021);
`else
        check("jal_valid", out_valid_o, 1);
        check("jal_data", out_data_o, 32'h0080006F);
`endif
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
